fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO (`wr`, `w_data`, `full`) among N producers.
- Uses registered round-robin arbitration with a bounded burst lock: a granted producer may write up to MAX_BURST consecutive words before the port is re-arbitrated.
- Guarantees the FIFO never sees `wr` while `full`, so no producer word is silently dropped.

Parameters:
- N, 4, number of requesters (2..16).
- B, 8, data word width; must equal the FIFO B.
- MAX_BURST, 4, maximum words per grant (>=1).
- IDW, 2, width of grant_id; must be >= clog2(N).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-requester write request; level, held while data is pending.
- data  input  N*B  flattened requester words; requester i occupies bits [i*B +: B].
- ack  output  N  one-hot or zero; ack[i]=1 means data[i] is written to the FIFO this cycle, and the producer advances its data.
- fifo_full  input  1  FIFO full flag.
- fifo_wr  output  1  FIFO write strobe.
- fifo_w_data  output  B  FIFO write data.
- grant_valid  output  1  a requester currently holds the port.
- grant_id  output  IDW  index of the granted requester; valid when grant_valid=1.

Behaviour:
- States: IDLE, BUSY. Registered state: grant_id, last_id, burst_cnt (width clog2(MAX_BURST+1)).
- Reset (async, any time, including mid-burst):
  - state=IDLE, grant_valid=0, grant_id=0, last_id=N-1, burst_cnt=0.
  - ack=0 and fifo_wr=0 immediately, because they are combinational from state.
  - After reset, requester 0 has the highest priority.
- IDLE:
  - fifo_wr=0, ack=0.
  - If req!=0: at the next edge, grant the first set req bit scanning last_id+1, last_id+2, ... modulo N. Set state=BUSY, grant_valid=1, burst_cnt=0.
  - Arbitration latency: 1 cycle from req to grant.
- BUSY, with g=grant_id:
  - fifo_wr = req[g] & ~fifo_full.
  - ack[g] = fifo_wr; all other ack bits are 0.
  - fifo_w_data = data[g]. In IDLE fifo_w_data is don't-care; the implementation drives data[grant_id].
  - On a write with burst_cnt==MAX_BURST-1: the word is written, then at the edge state=IDLE, last_id=g, grant_valid=0.
  - On a write with burst_cnt<MAX_BURST-1: burst_cnt+1, stay BUSY.
  - req[g]==0: no write that cycle; at the edge state=IDLE, last_id=g.
  - req[g]==1 and fifo_full==1: stall. Stay BUSY, burst_cnt unchanged, no write. There is no timeout; the lock holds until the FIFO drains.
- Throughput:
  - One write per cycle within a burst.
  - One idle cycle between grants (the IDLE arbitration cycle).
  - Steady-state utilisation with all requesters saturated is MAX_BURST/(MAX_BURST+1).
- Fairness: after a grant ends, the releasing requester has the lowest priority, so no requester waits longer than (N-1) bursts plus N arbitration cycles, given a draining FIFO.
- Requests arriving during BUSY: only sampled in IDLE. They never preempt the current grant.
- Simultaneous events:
  - fifo_full rising on the same cycle as the final burst word: no write. Stay BUSY and retry.
  - A FIFO read freeing space while full: the write occurs on the first cycle fifo_full=0.
- Invariants:
  - fifo_wr & fifo_full == 0 always.
  - ack is at most one-hot.
  - ack != 0 implies grant_valid == 1.
  - fifo_wr == |ack.

Test Plan:
- Single requester, long burst: MAX_BURST=4, FIFO empty, req[2] held for 6 words (D0..D5).
  - Response: grant_id=2 from cycle 1; ack[2]/fifo_wr high cycles 1-4 (D0-D3); cycle 5 idle; regrant at cycle 6; D4,D5 written cycles 6-7.
  - FIFO contents in order D0..D5.
- Round-robin fairness: req=4'b1111 continuously after reset, each producer supplying a tagged counter.
  - Response: grant order 0,1,2,3,0.
  - Each grant writes exactly 4 words, followed by 1 idle cycle.
  - ack never has more than one bit set.
- Full stall: FIFO W=2 (depth 4), no reads, req[1] continuous.
  - Response: 4 words written, then fifo_full=1 and fifo_wr held 0 with grant_valid=1 held.
  - A single FIFO read gives exactly one write on the next cycle, with burst_cnt continuing from its stalled value.
- Early release: req[3] for 2 words, then drops; req[0] asserted throughout.
  - Response: 2 writes from requester 3, then IDLE for 1 cycle, then grant_id=0.
  - No spurious write in the cycle req[3] is low.
- Reset mid-burst: assert reset during the 2nd word of a burst from requester 1.
  - Response: fifo_wr, ack and grant_valid drop in the same cycle.
  - After release, with req=4'b0011, requester 0 is granted first.
- Back-to-back wrap: N=4, last grant to requester 3, req=4'b1001.
  - Response: the next grant goes to requester 0, not 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port among N producers; a grant is released after MAX_BURST words or when its request drops.
// One IDLE arbitration cycle precedes every grant; a full FIFO stalls the holder in place without losing its burst position.
module fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int B         = 8,
   parameter int MAX_BURST = 4,
   parameter int IDW       = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*B-1:0] data,
   output logic [N-1:0]   ack,
   input  logic           fifo_full,
   output logic           fifo_wr,
   output logic [B-1:0]   fifo_w_data,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id
);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] last_id, last_id_nxt, grant_id_nxt;
   logic [CW-1:0]  burst_cnt, burst_cnt_nxt;
   logic [B-1:0]   words [N];
   logic [2*N-1:0] req_rot;
   logic [IDW:0]   start, pick;
   logic [IDW-1:0] pick_id;
   logic           found;

   for (genvar i = 0; i < N; i++) begin : g_words
      assign words[i] = data[i*B +: B];
   end

   // Rotate requests so bit 0 is the requester just after the last holder.
   always_comb begin
      start = {1'b0, last_id} + (IDW+1)'(1);
      if (start >= (IDW+1)'(N)) start = '0;
      req_rot = {req, req} >> start;
      found   = 1'b0;
      pick    = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_rot[k]) begin
            found = 1'b1;
            pick  = start + (IDW+1)'(k);
         end
      end
      if (pick >= (IDW+1)'(N)) pick = pick - (IDW+1)'(N);
      pick_id = pick[IDW-1:0];
   end

   always_comb begin
      state_nxt     = state;
      grant_id_nxt  = grant_id;
      last_id_nxt   = last_id;
      burst_cnt_nxt = burst_cnt;
      fifo_wr       = 1'b0;
      ack           = '0;
      fifo_w_data   = words[grant_id];
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt     = BUSY;
               grant_id_nxt  = pick_id;
               burst_cnt_nxt = '0;
            end
         end
         BUSY: begin
            fifo_wr       = req[grant_id] & ~fifo_full;
            ack[grant_id] = fifo_wr;
            if (!req[grant_id]) begin
               state_nxt   = IDLE;
               last_id_nxt = grant_id;
            end else if (fifo_wr) begin
               if (burst_cnt == CW'(MAX_BURST - 1)) begin
                  state_nxt   = IDLE;
                  last_id_nxt = grant_id;
               end else begin
                  burst_cnt_nxt = burst_cnt + CW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign grant_valid = (state == BUSY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant_id  <= '0;
         last_id   <= IDW'(N - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         grant_id  <= grant_id_nxt;
         last_id   <= last_id_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end
endmodule
